// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_pkg
// Brief   : Shared state encoding and constants for the delayed memory model.
// Revision: 1.0
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } e_mem_state;

    localparam int MEM_DEFAULT_LATENCY = 4;
    localparam int MEM_WORD_BYTES      = 4;

endpackage
`default_nettype wire

// File: rtl/mem_sp_array.sv
`default_nettype none
// ============================================================================
// Module  : mem_sp_array
// Brief   : Single-port 32-bit RAM (synchronous write, combinational read) with
//           a write-only backdoor port; the functional port wins on a collision.
// Revision: 1.0
// ============================================================================
module mem_sp_array
    import mem_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    input  logic              bd_we,
    input  logic [ADDR_W-1:0] bd_addr,
    input  logic [31:0]       bd_data
);

    logic [31:0] r_mem [DEPTH];

    // Functional write is issued last so it overrides a same-word backdoor write.
    always_ff @(posedge clk) begin
        if (bd_we) begin
            r_mem[bd_addr] <= bd_data;
        end
        if (we) begin
            r_mem[addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/mem_delayed_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mem_delayed_ctrl
// Brief   : Word memory answering one request at a time after LATENCY cycles.
//           Optional macro MEM_ADDR_CHECK_EN adds mem_err for bad addresses.
// Revision: 1.0
// ============================================================================
module mem_delayed_ctrl
    import mem_pkg::*;
#(
    parameter int LATENCY = MEM_DEFAULT_LATENCY,
    parameter int DEPTH   = 4096,
    parameter int ADDR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wr_data,
    input  logic              mem_wr_req,
    input  logic              mem_rd_req,
    output logic [31:0]       mem_rd_data,
    output logic              mem_ack,
    output logic              mem_busy,
    input  logic              init_wr_en,
    input  logic [ADDR_W-1:0] init_addr,
    input  logic [31:0]       init_data
`ifdef MEM_ADDR_CHECK_EN
    ,
    output logic              mem_err
`endif
);

    localparam logic [7:0] c_CNT_LOAD = 8'(LATENCY - 1);

    e_mem_state        r_state;
    logic [7:0]        r_cnt;
    logic [ADDR_W-1:0] r_index;
    logic [31:0]       r_wr_data;
    logic              r_is_write;
    logic              r_addr_bad;
    logic [31:0]       r_rd_data;

    logic              w_req;
    logic              w_addr_bad;
    logic              w_access;
    logic              w_arr_we;
    logic [31:0]       w_arr_rd_data;
    logic              w_unused_addr;

    assign w_req         = mem_wr_req | mem_rd_req;
    assign w_unused_addr = ^{mem_addr[31:ADDR_W+2], mem_addr[1:0]};

`ifdef MEM_ADDR_CHECK_EN
    localparam logic [32:0] c_BYTE_LIMIT = 33'(DEPTH) * 33'(MEM_WORD_BYTES);

    assign w_addr_bad = (mem_addr[1:0] != 2'b00) || ({1'b0, mem_addr} >= c_BYTE_LIMIT);
    assign mem_err    = (r_state == ACK) && r_addr_bad;
`else
    assign w_addr_bad = 1'b0;
`endif

    // The array is touched only on the last WAIT edge, and never for a flagged address.
    assign w_access = (r_state == WAIT) && (r_cnt == 8'd0);
    assign w_arr_we = w_access && r_is_write && !r_addr_bad;

    mem_sp_array #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .we      (w_arr_we),
        .addr    (r_index),
        .wr_data (r_wr_data),
        .rd_data (w_arr_rd_data),
        .bd_we   (init_wr_en),
        .bd_addr (init_addr),
        .bd_data (init_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= 8'd0;
            r_index    <= '0;
            r_wr_data  <= 32'h0;
            r_is_write <= 1'b0;
            r_addr_bad <= 1'b0;
            r_rd_data  <= 32'h0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_index    <= mem_addr[ADDR_W+1:2];
                        r_wr_data  <= mem_wr_data;
                        r_is_write <= mem_wr_req;
                        r_addr_bad <= w_addr_bad;
                        r_cnt      <= c_CNT_LOAD;
                        r_state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (r_cnt != 8'd0) begin
                        r_cnt <= r_cnt - 8'd1;
                    end else begin
                        if (!r_is_write) begin
                            r_rd_data <= r_addr_bad ? 32'h0 : w_arr_rd_data;
                        end
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_rd_data = r_rd_data;
    assign mem_ack     = (r_state == ACK);
    assign mem_busy    = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mem_delayed_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_delayed_ctrl
// Brief   : Self-checking bench for mem_delayed_ctrl (LATENCY=4 and LATENCY=1
//           instances); honours MEM_ADDR_CHECK_EN when defined.
// Revision: 1.0
// ============================================================================
module tb_mem_delayed_ctrl;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] addr, wdata, b_addr, b_wdata;
    logic        wr, rd, b_wr, b_rd;
    logic        init_wr_en;
    logic [11:0] init_addr;
    logic [31:0] init_data;
    logic [31:0] a_rd_data, b_rd_data;
    logic        a_ack, a_busy, a_err, b_ack, b_busy, b_err;

    exp_t        exp_q[$];
    logic [31:0] mdl [0:4095];
    logic [31:0] last_a, last_b;
    int          n_vec;
    int          n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_delayed_ctrl #(.LATENCY(4), .DEPTH(4096), .ADDR_W(12)) u_dut_a (
        .clk(clk), .rst(rst), .mem_addr(addr), .mem_wr_data(wdata),
        .mem_wr_req(wr), .mem_rd_req(rd), .mem_rd_data(a_rd_data),
        .mem_ack(a_ack), .mem_busy(a_busy), .init_wr_en(init_wr_en),
        .init_addr(init_addr), .init_data(init_data)
`ifdef MEM_ADDR_CHECK_EN
        , .mem_err(a_err)
`endif
    );

    mem_delayed_ctrl #(.LATENCY(1), .DEPTH(4096), .ADDR_W(12)) u_dut_b (
        .clk(clk), .rst(rst), .mem_addr(b_addr), .mem_wr_data(b_wdata),
        .mem_wr_req(b_wr), .mem_rd_req(b_rd), .mem_rd_data(b_rd_data),
        .mem_ack(b_ack), .mem_busy(b_busy), .init_wr_en(init_wr_en),
        .init_addr(init_addr), .init_data(init_data)
`ifdef MEM_ADDR_CHECK_EN
        , .mem_err(b_err)
`endif
    );

`ifndef MEM_ADDR_CHECK_EN
    assign a_err = 1'b0;
    assign b_err = 1'b0;
`endif

    function automatic bit bad_addr(input logic [31:0] a);
`ifdef MEM_ADDR_CHECK_EN
        return (a[1:0] != 2'b00) || (a >= 32'h0000_4000);
`else
        return 1'b0;
`endif
    endfunction

    // Expected result of one accepted request, computed from the bench model.
    task automatic push_exp(input bit on_b, input bit w, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   idx;
        idx   = int'(a[13:2]);
        e.err = bad_addr(a);
        if (w) begin
            e.data = on_b ? last_b : last_a;
            if (!e.err) mdl[idx] = d;
        end else begin
            e.data = e.err ? 32'h0 : mdl[idx];
            if (on_b) last_b = e.data;
            else      last_a = e.data;
        end
        exp_q.push_back(e);
    endtask

    task automatic backdoor(input int idx, input logic [31:0] d);
        init_wr_en = 1'b1;
        init_addr  = idx[11:0];
        init_data  = d;
        @(negedge clk);
        init_wr_en = 1'b0;
        mdl[idx]   = d;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic issue(input bit on_b, input bit w, input bit r, input logic [31:0] a, input logic [31:0] d);
        if (on_b) begin
            b_wr = w; b_rd = r; b_addr = a; b_wdata = d;
        end else begin
            wr = w; rd = r; addr = a; wdata = d;
        end
        push_exp(on_b, w, a, d);
        @(negedge clk);
        wr = 1'b0; rd = 1'b0; b_wr = 1'b0; b_rd = 1'b0;
    endtask

    task automatic wait_ack(input bit on_b, input int budget, output bit got, output int cyc);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc <= budget) begin
            if ((on_b ? b_ack : a_ack) === 1'b1) got = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        wr = 0; rd = 0; b_wr = 0; b_rd = 0; addr = 0; wdata = 0; b_addr = 0; b_wdata = 0;
        init_wr_en = 0; init_addr = 0; init_data = 0;
        repeat (2) @(negedge clk);
        n_vec++; if (a_ack !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b want 0", a_ack); end
        n_vec++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        n_vec++; if (a_rd_data !== 32'h0) begin n_bad++; $display("FAIL reset_rd_data: got %h want 0", a_rd_data); end
        n_vec++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", a_err); end
        n_vec++; if (b_busy !== 1'b0) begin n_bad++; $display("FAIL reset_b_busy: got %b want 0", b_busy); end
        rst = 1'b0;
        last_a = 32'h0;
        last_b = 32'h0;
        @(negedge clk);
    endtask

    task automatic test_read_latency;
        exp_t e;
        backdoor(3, 32'hDEAD_BEEF);
        backdoor(0, 32'h0BAD_F00D);
        issue(1'b0, 1'b0, 1'b1, 32'd12, 32'h0);
        for (int j = 0; j <= 5; j++) begin
            n_vec++; if (a_ack !== (j == 4)) begin n_bad++; $display("FAIL lat_ack j=%0d: got %b want %b", j, a_ack, (j == 4)); end
            n_vec++; if (a_busy !== (j <= 4)) begin n_bad++; $display("FAIL lat_busy j=%0d: got %b want %b", j, a_busy, (j <= 4)); end
            if (j == 4) begin
                e = exp_q.pop_front();
                n_vec++; if (a_rd_data !== e.data) begin n_bad++; $display("FAIL lat_rd_data: got %h want %h", a_rd_data, e.data); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_write_then_read;
        exp_t e;
        bit   got;
        int   cyc;
        issue(1'b0, 1'b1, 1'b0, 32'd8, 32'h0000_1234);
        wait_ack(1'b0, 10, got, cyc);
        n_vec++; if (!got || cyc != 4) begin n_bad++; $display("FAIL wr_ack_time: got %0d (seen %b) want 4", cyc, got); end
        e = exp_q.pop_front();
        n_vec++; if (a_rd_data !== e.data) begin n_bad++; $display("FAIL wr_keeps_rd_data: got %h want %h", a_rd_data, e.data); end
        @(negedge clk);
        issue(1'b0, 1'b0, 1'b1, 32'd8, 32'h0);
        wait_ack(1'b0, 10, got, cyc);
        e = exp_q.pop_front();
        n_vec++; if (!got || a_rd_data !== e.data) begin n_bad++; $display("FAIL rd_after_wr: got %h want %h", a_rd_data, e.data); end
        @(negedge clk);
    endtask

    task automatic test_collision;
        exp_t e;
        bit   got;
        int   cyc;
        int   extra;
        issue(1'b0, 1'b1, 1'b1, 32'd16, 32'h0000_0055);
        wait_ack(1'b0, 10, got, cyc);
        e = exp_q.pop_front();
        n_vec++; if (!got || a_rd_data !== e.data) begin n_bad++; $display("FAIL coll_ack_data: got %h want %h", a_rd_data, e.data); end
        extra = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            if (a_ack === 1'b1) extra++;
        end
        n_vec++; if (extra != 0) begin n_bad++; $display("FAIL coll_single_ack: got %0d extra acks want 0", extra); end
        issue(1'b0, 1'b0, 1'b1, 32'd16, 32'h0);
        wait_ack(1'b0, 10, got, cyc);
        e = exp_q.pop_front();
        n_vec++; if (!got || a_rd_data !== e.data) begin n_bad++; $display("FAIL coll_readback: got %h want %h", a_rd_data, e.data); end
        @(negedge clk);
    endtask

    task automatic test_held_request;
        exp_t e;
        bit   exp_ack, exp_busy;
        rd   = 1'b1;
        addr = 32'd12;
        push_exp(1'b0, 1'b0, 32'd12, 32'h0);
        push_exp(1'b0, 1'b0, 32'd12, 32'h0);
        @(negedge clk);
        for (int j = 0; j <= 11; j++) begin
            exp_ack  = (j == 4) || (j == 10);
            exp_busy = (j <= 4) || (j >= 6 && j <= 10);
            n_vec++; if (a_ack !== exp_ack) begin n_bad++; $display("FAIL held_ack j=%0d: got %b want %b", j, a_ack, exp_ack); end
            n_vec++; if (a_busy !== exp_busy) begin n_bad++; $display("FAIL held_busy j=%0d: got %b want %b", j, a_busy, exp_busy); end
            if (exp_ack && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_vec++; if (a_rd_data !== e.data) begin n_bad++; $display("FAIL held_rd_data j=%0d: got %h want %h", j, a_rd_data, e.data); end
            end
            if (j == 11) rd = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_backdoor_priority;
        exp_t e;
        bit   got;
        int   cyc;
        issue(1'b0, 1'b1, 1'b0, 32'd24, 32'hF00D_CAFE);
        for (int j = 0; j < 4; j++) begin
            init_wr_en = (j == 0) || (j == 2);
            init_addr  = (j == 0) ? 12'd7 : 12'd6;
            init_data  = (j == 0) ? 32'h0000_0077 : 32'h1111_1111;
            @(negedge clk);
        end
        init_wr_en = 1'b0;
        mdl[7] = 32'h0000_0077;
        n_vec++; if (a_ack !== 1'b1) begin n_bad++; $display("FAIL bd_wr_ack: got %b want 1", a_ack); end
        e = exp_q.pop_front();
        @(negedge clk);
        issue(1'b0, 1'b0, 1'b1, 32'd24, 32'h0);
        wait_ack(1'b0, 10, got, cyc);
        e = exp_q.pop_front();
        n_vec++; if (!got || a_rd_data !== e.data) begin n_bad++; $display("FAIL bd_func_wins: got %h want %h", a_rd_data, e.data); end
        @(negedge clk);
        issue(1'b0, 1'b0, 1'b1, 32'd28, 32'h0);
        wait_ack(1'b0, 10, got, cyc);
        e = exp_q.pop_front();
        n_vec++; if (!got || a_rd_data !== e.data) begin n_bad++; $display("FAIL bd_while_busy: got %h want %h", a_rd_data, e.data); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write;
        exp_t e;
        bit   got;
        int   cyc;
        backdoor(5, 32'h0000_0007);
        wr = 1'b1; addr = 32'd20; wdata = 32'hAAAA_5555;
        @(negedge clk);
        wr = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", a_busy); end
        n_vec++; if (a_ack !== 1'b0) begin n_bad++; $display("FAIL rst_mid_ack: got %b want 0", a_ack); end
        n_vec++; if (a_rd_data !== 32'h0) begin n_bad++; $display("FAIL rst_mid_rd_data: got %h want 0", a_rd_data); end
        @(negedge clk);
        rst = 1'b0;
        last_a = 32'h0;
        last_b = 32'h0;
        @(negedge clk);
        issue(1'b0, 1'b0, 1'b1, 32'd20, 32'h0);
        wait_ack(1'b0, 10, got, cyc);
        e = exp_q.pop_front();
        n_vec++; if (!got || a_rd_data !== e.data) begin n_bad++; $display("FAIL rst_drops_write: got %h want %h", a_rd_data, e.data); end
        @(negedge clk);
    endtask

    task automatic test_latency1_and_addr;
        exp_t e;
        bit   got;
        int   cyc;
        issue(1'b1, 1'b0, 1'b1, 32'd12, 32'h0);
        for (int j = 0; j <= 2; j++) begin
            n_vec++; if (b_ack !== (j == 1)) begin n_bad++; $display("FAIL lat1_ack j=%0d: got %b want %b", j, b_ack, (j == 1)); end
            n_vec++; if (b_busy !== (j <= 1)) begin n_bad++; $display("FAIL lat1_busy j=%0d: got %b want %b", j, b_busy, (j <= 1)); end
            if (j == 1) begin
                e = exp_q.pop_front();
                n_vec++; if (b_rd_data !== e.data) begin n_bad++; $display("FAIL lat1_rd_data: got %h want %h", b_rd_data, e.data); end
            end
            @(negedge clk);
        end
        issue(1'b1, 1'b0, 1'b1, 32'd3, 32'h0);
        wait_ack(1'b1, 5, got, cyc);
        e = exp_q.pop_front();
        n_vec++; if (!got || cyc != 1) begin n_bad++; $display("FAIL misalign_ack_time: got %0d (seen %b) want 1", cyc, got); end
        n_vec++; if (b_rd_data !== e.data) begin n_bad++; $display("FAIL misalign_rd_data: got %h want %h", b_rd_data, e.data); end
        n_vec++; if (b_err !== e.err) begin n_bad++; $display("FAIL misalign_err: got %b want %b", b_err, e.err); end
        @(negedge clk);
        issue(1'b0, 1'b0, 1'b1, 32'h0000_400C, 32'h0);
        wait_ack(1'b0, 10, got, cyc);
        e = exp_q.pop_front();
        n_vec++; if (!got || a_rd_data !== e.data) begin n_bad++; $display("FAIL range_rd_data: got %h want %h", a_rd_data, e.data); end
        n_vec++; if (a_err !== e.err) begin n_bad++; $display("FAIL range_err: got %b want %b", a_err, e.err); end
        @(negedge clk);
        n_vec++; if (a_err !== 1'b0) begin n_bad++; $display("FAIL err_pulse_width: got %b want 0", a_err); end
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_read_latency();
        test_write_then_read();
        test_collision();
        test_held_request();
        test_backdoor_priority();
        test_reset_mid_write();
        test_latency1_and_addr();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", n_vec);
        $fatal(1);
    end

endmodule
`default_nettype wire
